// File: rtl/fb_wr_arbiter.sv
// fb_wr_arbiter: round-robin framebuffer write-port arbiter with built-in clear sequencer
module fb_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int FB_DEPTH = 42400,
  parameter logic [7:0] CLEAR_BYTE = 8'h00
) (
  input  logic                 clock25,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [16*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 clear_start,
  output logic                 busy,
  output logic                 clear_done,
  output logic                 drop_err,
  output logic [15:0]          mem_add,
  output logic [0:7]           mem_out,
  output logic                 mem_write
);
  typedef enum logic {ARB, CLEAR} state_t;
  state_t r_state, w_state_nxt;
  logic [2:0] r_rr_ptr, w_gnt, w_ptr_nxt;
  logic [15:0] r_clr_cnt, w_addr;
  logic [7:0] w_data;
  logic w_gnt_vld, w_xfer, w_last;
  int w_j;
  // walk downward so the candidate closest to rr_ptr is the one left standing
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt = '0;
    w_j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid[w_j]) begin
        w_gnt_vld = 1'b1;
        w_gnt = 3'(w_j);
      end
    end
  end
  assign req_ready = (!reset && r_state == ARB && !clear_start && w_gnt_vld) ? NUM_REQ'(1) << w_gnt : '0;
  assign w_xfer = |req_ready;
  assign w_addr = req_addr[16*w_gnt +: 16];
  assign w_data = req_data[8*w_gnt +: 8];
  assign w_last = r_clr_cnt == 16'(FB_DEPTH - 1);
  assign w_ptr_nxt = (w_gnt == 3'(NUM_REQ - 1)) ? 3'd0 : w_gnt + 3'd1;
  assign busy = r_state == CLEAR;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ARB && clear_start) w_state_nxt = CLEAR;
    else if (r_state == CLEAR && w_last) w_state_nxt = ARB;
  end
  always_ff @(posedge clock25) begin
    if (reset) begin
      r_state <= ARB;
      r_rr_ptr <= '0;
      r_clr_cnt <= '0;
      mem_write <= 1'b0;
      mem_add <= '0;
      mem_out <= '0;
      clear_done <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      mem_write <= 1'b0;
      clear_done <= 1'b0;
      drop_err <= 1'b0;
      if (r_state == CLEAR) begin
        mem_write <= 1'b1;
        mem_add <= r_clr_cnt;
        mem_out <= CLEAR_BYTE;
        clear_done <= w_last;
        r_clr_cnt <= w_last ? 16'd0 : r_clr_cnt + 16'd1;
      end else if (clear_start) begin
        r_clr_cnt <= '0;
      end else if (w_xfer) begin
        r_rr_ptr <= w_ptr_nxt;
        // out-of-range requests are consumed but never reach the buffer
        if (w_addr < 16'(FB_DEPTH)) begin
          mem_write <= 1'b1;
          mem_add <= w_addr;
          mem_out <= w_data;
        end else begin
          drop_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_wr_arbiter.sv
// tb_fb_wr_arbiter: directed table-driven bench for fb_wr_arbiter (NUM_REQ=2, FB_DEPTH=42400)
module tb_fb_wr_arbiter;
  logic clock25 = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic clear_start = 1'b0;
  logic [1:0] req_ready;
  logic busy, clear_done, drop_err, mem_write;
  logic [15:0] mem_add;
  logic [0:7] mem_out;
  int n_chk = 0;
  int n_fail = 0;
  int bad;
  fb_wr_arbiter dut (
    .clock25(clock25), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start), .busy(busy),
    .clear_done(clear_done), .drop_err(drop_err), .mem_add(mem_add), .mem_out(mem_out),
    .mem_write(mem_write)
  );
  always #5 clock25 = ~clock25;
  typedef struct {
    logic [1:0] v;
    logic [15:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] rdy;
    logic wr;
    logic [15:0] add;
    logic [7:0] dout;
    logic drop;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clock25);
    #1;
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_write"}, 32'(mem_write), 0);
    chk({nm, "_add"}, 32'(mem_add), 0);
    chk({nm, "_out"}, 32'(mem_out), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(clear_done), 0);
    chk({nm, "_drop"}, 32'(drop_err), 0);
  endtask
  initial begin
    tv[0] = '{2'b11, 16'h0010, 16'h0020, 8'h11, 8'h22, 2'b01, 1'b1, 16'h0010, 8'h11, 1'b0};
    tv[1] = '{2'b11, 16'h0010, 16'h0020, 8'h11, 8'h22, 2'b10, 1'b1, 16'h0020, 8'h22, 1'b0};
    tv[2] = '{2'b11, 16'h0010, 16'h0020, 8'h11, 8'h22, 2'b01, 1'b1, 16'h0010, 8'h11, 1'b0};
    tv[3] = '{2'b11, 16'h0010, 16'h0020, 8'h11, 8'h22, 2'b10, 1'b1, 16'h0020, 8'h22, 1'b0};
    tv[4] = '{2'b01, 16'h00A5, 16'h0000, 8'h80, 8'h00, 2'b01, 1'b1, 16'h00A5, 8'h80, 1'b0};
    tv[5] = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0};
    tv[6] = '{2'b10, 16'h0000, 16'd42400, 8'h00, 8'hFF, 2'b10, 1'b0, 16'h0000, 8'h00, 1'b1};
    tv[7] = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0};
    tv[8] = '{2'b10, 16'h0000, 16'd42399, 8'h00, 8'h5A, 2'b10, 1'b1, 16'd42399, 8'h5A, 1'b0};
    tv[9] = '{2'b01, 16'h0000, 16'h0000, 8'h01, 8'h00, 2'b01, 1'b1, 16'h0000, 8'h01, 1'b0};
    // power-on reset
    repeat (2) cyc();
    chk("rst_ready", 32'(req_ready), 0);
    chk_idle("rst");
    reset = 1'b0;
    foreach (tv[i]) begin
      req_valid = tv[i].v;
      req_addr = {tv[i].a1, tv[i].a0};
      req_data = {tv[i].d1, tv[i].d0};
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      cyc();
      chk($sformatf("v%0d_write", i), 32'(mem_write), 32'(tv[i].wr));
      chk($sformatf("v%0d_drop", i), 32'(drop_err), 32'(tv[i].drop));
      if (tv[i].wr) begin
        chk($sformatf("v%0d_add", i), 32'(mem_add), 32'(tv[i].add));
        chk($sformatf("v%0d_out", i), 32'(mem_out), 32'(tv[i].dout));
      end
    end
    // reset held 3 cycles with both requesters active
    req_valid = 2'b11;
    req_addr = {16'h0020, 16'h0010};
    req_data = {8'h22, 8'h11};
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_rst_ready", 32'(req_ready), 0);
      cyc();
      chk_idle("mid_rst");
    end
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'(2'b01));
    cyc();
    chk("post_rst_add", 32'(mem_add), 32'h10);
    chk("post_rst_bit0", 32'(mem_out[0]), 0);
    // full clear pre-empting req0
    req_valid = 2'b01;
    req_addr = {16'h0000, 16'h0030};
    req_data = {8'h00, 8'h33};
    clear_start = 1'b1;
    #1;
    chk("clr_preempt_ready", 32'(req_ready), 0);
    cyc();
    clear_start = 1'b0;
    chk("clr_busy", 32'(busy), 1);
    chk("clr_first_write", 32'(mem_write), 0);
    bad = 0;
    for (int i = 0; i < 42400; i++) begin
      cyc();
      if (!(mem_write === 1'b1 && mem_add === 16'(i) && mem_out === 8'h00 &&
            busy === (i != 42399) && clear_done === (i == 42399) &&
            req_ready === ((i == 42399) ? 2'b01 : 2'b00))) begin
        if (bad == 0)
          $display("FAIL clr_step %0d: wr=%b add=%0d out=%h busy=%b done=%b rdy=%b", i, mem_write,
                   mem_add, mem_out, busy, clear_done, req_ready);
        bad++;
      end
    end
    chk("clr_seq_errors", 32'(bad), 0);
    cyc();
    chk("clr_after_done", 32'(clear_done), 0);
    chk("clr_after_write", 32'(mem_write), 1);
    chk("clr_after_add", 32'(mem_add), 32'h30);
    chk("clr_after_out", 32'(mem_out), 32'h33);
    // restart attempt mid-clear, then reset at clr_cnt=100
    req_valid = 2'b00;
    clear_start = 1'b1;
    cyc();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      clear_start = (i == 10);
      cyc();
      if (!(mem_write === 1'b1 && mem_add === 16'(i) && clear_done === 1'b0 && busy === 1'b1))
        bad++;
    end
    clear_start = 1'b0;
    chk("abort_seq_errors", 32'(bad), 0);
    reset = 1'b1;
    cyc();
    chk_idle("abort_rst");
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (busy !== 1'b0 || clear_done !== 1'b0 || mem_write !== 1'b0) bad++;
    end
    chk("abort_quiet", 32'(bad), 0);
    req_valid = 2'b10;
    req_addr = {16'h0040, 16'h0000};
    req_data = {8'hC3, 8'h00};
    #1;
    chk("abort_arb_ready", 32'(req_ready), 32'(2'b10));
    cyc();
    chk("abort_arb_add", 32'(mem_add), 32'h40);
    chk("abort_arb_out", 32'(mem_out), 32'hC3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
